pll_lock_reset_seq: RTL and testbench

- Sits directly downstream of the PLL wrapper and consumes its asynchronous `locked` output.
- Debounces lock and releases per-domain resets in a fixed order once lock is stable; re-asserts all of them immediately on loss of lock.
- Runs on the free-running reference clock, so it keeps working while the PLL output is stopped.
- With the optional feature, drives the PLL's `rst` input to retry when lock is not achieved in time.

---
 rtl/pll_lock_reset_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq
// Debounces the PLL lock indication on the free-running reference clock and
// releases the per-domain resets one at a time once lock is stable. Any loss
// of lock after release has begun re-asserts every domain reset on the next
// edge and is counted in lost_lock_cnt (saturating).
// Optional feature macro: PLL_LOCK_TIMEOUT_EN. When defined, a lock that does
// not complete within TIMEOUT_CYCLES pulses pll_rst for PLL_RST_CYCLES cycles.
// dbg_state exposes the FSM state for observation.
// `ready` is a registered level, not a handshake: it is high exactly while all
// domains are released and falls with the edge that re-asserts them.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_CYCLES = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [7:0]             lost_lock_cnt,
    output logic [2:0]             dbg_state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int IW = $clog2(NUM_DOMAINS + 1);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [2:0] S_PLL_RST   = 3'd4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PRST_LAST = PW'(PLL_RST_CYCLES - 1);
`endif

    // Counters compare against "last value" so a count of N fits in N's width.
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] STAGE_ALL   = IW'(NUM_DOMAINS);

    // Reject parameter values the sequencing cannot honour.
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || NUM_DOMAINS < 1 || STAGE_GAP < 1 ||
        TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : g_param_check
        $error("pll_lock_reset_seq: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [2:0]             state_q, state_d;
    logic [SW-1:0]          stable_cnt_q, stable_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]          stage_q, stage_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;
    logic [7:0]             lost_q, lost_d;
    logic                   go_release;
    logic                   lose_lock;
`ifdef PLL_LOCK_TIMEOUT_EN
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [PW-1:0]          prst_cnt_q, prst_cnt_d;
    logic                   pll_rst_q, pll_rst_d;
`endif

    // Bring the asynchronous lock indication into the refclk domain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state and next-output decisions, all driven by locked_s only.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        stage_d      = stage_q;
        domain_rst_d = domain_rst_q;
        ready_d      = ready_q;
        lost_d       = lost_q;
        go_release   = 1'b0;
        lose_lock    = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        prst_cnt_d   = prst_cnt_q;
        pll_rst_d    = pll_rst_q;
`endif

        case (state_q)
            S_WAIT_LOCK: begin
                domain_rst_d = '1;
                ready_d      = 1'b0;
                if (locked_s) begin
                    // This cycle already counts as the first stable one.
                    if (STABLE_CYCLES == 1) begin
                        go_release = 1'b1;
                    end else begin
                        state_d      = S_STABLE;
                        stable_cnt_d = SW'(1);
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d      = S_WAIT_LOCK;
                    stable_cnt_d = '0;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    go_release = 1'b1;
                end else begin
                    stable_cnt_d = stable_cnt_q + SW'(1);
                end
            end
            S_RELEASE: begin
                if (!locked_s) begin
                    lose_lock = 1'b1;
                end else if (stage_q == STAGE_ALL) begin
                    state_d   = S_RUN;
                    ready_d   = 1'b1;
                    stage_d   = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (IW'(i) == stage_q) begin
                            domain_rst_d[i] = 1'b0;
                        end
                    end
                    stage_d   = stage_q + IW'(1);
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    lose_lock = 1'b1;
                end
            end
`ifdef PLL_LOCK_TIMEOUT_EN
            S_PLL_RST: begin
                // locked_s is deliberately ignored while the PLL is being reset.
                domain_rst_d = '1;
                ready_d      = 1'b0;
                if (prst_cnt_q == PRST_LAST) begin
                    state_d    = S_WAIT_LOCK;
                    pll_rst_d  = 1'b0;
                    prst_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    prst_cnt_d = prst_cnt_q + PW'(1);
                end
            end
`endif
            default: begin
                state_d      = S_WAIT_LOCK;
                stable_cnt_d = '0;
                gap_cnt_d    = '0;
                stage_d      = '0;
                domain_rst_d = '1;
                ready_d      = 1'b0;
            end
        endcase

        if (go_release) begin
            state_d         = S_RELEASE;
            stable_cnt_d    = '0;
            domain_rst_d    = '1;
            domain_rst_d[0] = 1'b0;
            stage_d         = IW'(1);
            gap_cnt_d       = '0;
        end

        // Loss of lock after release began beats any release due this cycle.
        if (lose_lock) begin
            state_d      = S_WAIT_LOCK;
            domain_rst_d = '1;
            ready_d      = 1'b0;
            stage_d      = '0;
            gap_cnt_d    = '0;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end

`ifdef PLL_LOCK_TIMEOUT_EN
        // Timeout spans WAIT_LOCK/STABLE glitches; only a release clears it.
        if (state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
            if (go_release) begin
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = S_PLL_RST;
                    pll_rst_d    = 1'b1;
                    stable_cnt_d = '0;
                    prst_cnt_d   = '0;
                    domain_rst_d = '1;
                    ready_d      = 1'b0;
                end
            end
        end
`endif
    end

    // Register state, counters and every output.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT_LOCK;
            stable_cnt_q <= '0;
            gap_cnt_q    <= '0;
            stage_q      <= '0;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            lost_q       <= 8'd0;
`ifdef PLL_LOCK_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            prst_cnt_q   <= '0;
            pll_rst_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            stage_q      <= stage_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            lost_q       <= lost_d;
`ifdef PLL_LOCK_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            prst_cnt_q   <= prst_cnt_d;
            pll_rst_q    <= pll_rst_d;
`endif
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    assign pll_rst = pll_rst_q;
`else
    assign pll_rst = 1'b0;
`endif
    assign domain_rst    = domain_rst_q;
    assign ready         = ready_q;
    assign lost_lock_cnt = lost_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq
// Bench for pll_lock_reset_seq with STABLE_CYCLES=8, STAGE_GAP=4,
// NUM_DOMAINS=3, SYNC_STAGES=2, TIMEOUT_CYCLES=100, PLL_RST_CYCLES=8.
// The reference model tracks the length of the current run of synchronized
// lock samples; outputs follow from that length with plain arithmetic.
module tb_pll_lock_reset_seq;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int N      = 3;
    localparam int GAP    = 4;
    localparam int TMO    = 100;
    localparam int PRST   = 8;
    localparam int W      = 13;

    // ---------------- clock / reset ----------------
    logic         refclk;
    logic         rst;
    logic         locked;
    logic         pll_rst;
    logic [N-1:0] domain_rst;
    logic         ready;
    logic [7:0]   lost_lock_cnt;
    logic [2:0]   dbg_state;

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    pll_lock_reset_seq #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .NUM_DOMAINS   (N),
        .STAGE_GAP     (GAP),
        .TIMEOUT_CYCLES(TMO),
        .PLL_RST_CYCLES(PRST)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .domain_rst   (domain_rst),
        .ready        (ready),
        .lost_lock_cnt(lost_lock_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        dq_name[$];
    int           dq_act[$];
    int           dq_exp[$];
    int           checks = 0;
    int           errors = 0;

    // ---------------- reference model ----------------
    int   m_run;
    int   m_lost;
    bit   m_in_prst;
`ifdef PLL_LOCK_TIMEOUT_EN
    int   m_tmo;
    int   m_prst_left;
`endif
    logic [2:0] hist;
    bit   skip_adv;

    function automatic void model_reset();
        m_run     = 0;
        m_lost    = 0;
        m_in_prst = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        m_tmo       = 0;
        m_prst_left = 0;
`endif
    endfunction

    // One clock edge, given the synchronized lock sample the design acts on.
    function automatic void model_advance(input logic s);
`ifdef PLL_LOCK_TIMEOUT_EN
        int run_before;
        run_before = m_run;
        if (m_in_prst) begin
            if (m_prst_left == 0) begin
                m_in_prst = 1'b0;
                m_tmo     = 0;
            end else begin
                m_prst_left--;
            end
            return;
        end
`endif
        if (s) begin
            m_run++;
        end else begin
            if (m_run >= STABLE && m_lost < 255) m_lost++;
            m_run = 0;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        if (run_before < STABLE) begin
            if (m_run >= STABLE) begin
                m_tmo = 0;
            end else begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    m_in_prst   = 1'b1;
                    m_prst_left = PRST - 1;
                    m_run       = 0;
                end
            end
        end
`endif
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [N-1:0] d;
        logic         r;
        for (int i = 0; i < N; i++) d[i] = (m_run >= STABLE + i * GAP) ? 1'b0 : 1'b1;
        r = (m_run >= STABLE + (N - 1) * GAP + 1);
        return {m_in_prst, r, 8'(m_lost), d};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after an edge: queue the expectation for that edge, then
    // drive locked for the coming cycle and move to just after the next edge.
    task automatic step(input logic lvl);
        if (skip_adv) skip_adv = 1'b0;
        else model_advance(hist[2]);
        exp_q.push_back(model_out());
        locked = lvl;
        hist   = {hist[1:0], lvl};
        @(posedge refclk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        hist     = 3'b000;
        skip_adv = 1'b1;
        repeat (2) begin
            @(posedge refclk);
            #2;
        end
        rst = 1'b0;
    endtask

    task automatic dcheck(input string name, input int act, input int exp);
        dq_name.push_back(name);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    // Hold locked at lvl for n cycles; report edges at which each bit cleared
    // and ready rose, counted from the first held cycle (-1 if never).
    task automatic hold_and_time(input logic lvl, input int n,
                                 output int t0, output int t1, output int t2, output int tr);
        t0 = -1; t1 = -1; t2 = -1; tr = -1;
        for (int k = 0; k < n; k++) begin
            step(lvl);
            if (t0 < 0 && domain_rst[0] == 1'b0) t0 = k + 1;
            if (t1 < 0 && domain_rst[1] == 1'b0) t1 = k + 1;
            if (t2 < 0 && domain_rst[2] == 1'b0) t2 = k + 1;
            if (tr < 0 && ready == 1'b1) tr = k + 1;
        end
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_name;
    int           mon_a;
    int           mon_e;

    always @(negedge refclk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {pll_rst, ready, lost_lock_cnt, domain_rst};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t actual pll_rst=%b ready=%b lost=%0d dom=%b required pll_rst=%b ready=%b lost=%0d dom=%b",
                         $time, mon_act[12], mon_act[11], mon_act[10:3], mon_act[2:0],
                         mon_exp[12], mon_exp[11], mon_exp[10:3], mon_exp[2:0]);
            end
        end
        while (dq_name.size() != 0) begin
            mon_name = dq_name.pop_front();
            mon_a    = dq_act.pop_front();
            mon_e    = dq_exp.pop_front();
            checks++;
            if (mon_a != mon_e) begin
                errors++;
                $display("FAIL %s actual=%0d required=%0d", mon_name, mon_a, mon_e);
            end
        end
    end

    // ---------------- stimulus ----------------
    int b0, b1, b2, rd, td, hi, lo, hi_cnt, nrise, rise0, rise1, rise2;
    logic prev;

    initial begin
        rst    = 1'b1;
        locked = 1'b0;

        // 1: steady lock from reset, release order and timing.
        do_reset();
        hold_and_time(1'b1, 30, b0, b1, b2, rd);
        dcheck("s1_bit0_edge", b0, SYNC + STABLE);
        dcheck("s1_bit1_edge", b1, SYNC + STABLE + GAP);
        dcheck("s1_bit2_edge", b2, SYNC + STABLE + 2 * GAP);
        dcheck("s1_ready_edge", rd, SYNC + STABLE + 2 * GAP + 1);

        // 3: loss of lock in RUN, then re-lock.
        td = -1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0);
            if (td < 0 && domain_rst == 3'b111 && ready == 1'b0) td = k + 1;
        end
        dcheck("s3_drop_edges", td, SYNC + 1);
        dcheck("s3_lost_cnt", int'(lost_lock_cnt), 1);
        hold_and_time(1'b1, 30, b0, b1, b2, rd);
        dcheck("s3_relock_bit0", b0, SYNC + STABLE);
        dcheck("s3_relock_ready", rd, SYNC + STABLE + 2 * GAP + 1);

        // 2: 3-cycle glitch during STABLE restarts the debounce.
        do_reset();
        repeat (4) step(1'b1);
        repeat (3) step(1'b0);
        hold_and_time(1'b1, 25, b0, b1, b2, rd);
        dcheck("s2_bit0_after_relock", b0, SYNC + STABLE);
        dcheck("s2_lost_cnt", int'(lost_lock_cnt), 0);

        // 4: 300 losses after release saturate the counter.
        for (int n = 0; n < 300; n++) begin
            hi = $urandom_range(STABLE + 12, STABLE);
            lo = $urandom_range(4, 1);
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
        repeat (4) step(1'b0);
        dcheck("s4_lost_saturated", int'(lost_lock_cnt), 255);

        // 5: asynchronous reset midway through RELEASE.
        repeat (SYNC + STABLE + 3) step(1'b1);
        dcheck("s5_mid_release_dom", int'(domain_rst), 6);
        rst = 1'b1;
        #1;
        dcheck("s5_async_dom", int'(domain_rst), 7);
        dcheck("s5_async_ready", int'(ready), 0);
        dcheck("s5_async_lost", int'(lost_lock_cnt), 0);
        dcheck("s5_async_pll_rst", int'(pll_rst), 0);
        do_reset();

        // 6: lock never arrives.
        do_reset();
        hi_cnt = 0; nrise = 0; rise0 = -1; rise1 = -1; rise2 = -1; prev = 1'b0;
        for (int k = 0; k < 330; k++) begin
            step(1'b0);
            if (pll_rst === 1'b1) begin
                hi_cnt++;
                if (!prev) begin
                    if (nrise == 0) rise0 = k + 1;
                    if (nrise == 1) rise1 = k + 1;
                    if (nrise == 2) rise2 = k + 1;
                    nrise++;
                end
            end
            prev = (pll_rst === 1'b1);
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        dcheck("s6_rise_count", nrise, 3);
        dcheck("s6_rise0", rise0, TMO);
        dcheck("s6_rise1", rise1, TMO + (TMO + PRST));
        dcheck("s6_rise2", rise2, TMO + 2 * (TMO + PRST));
        dcheck("s6_high_cycles", hi_cnt, 3 * PRST);
`else
        dcheck("s6_rise_count", nrise, 0);
        dcheck("s6_high_cycles", hi_cnt, 0);
`endif

        // Randomized lock waveform against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            lo = $urandom_range(30, 1);
            hi = $urandom_range(1, 0);
            repeat (lo) step(hi[0]);
        end
        repeat (25) step(1'b1);
        dcheck("rand_final_ready", int'(ready), 1);

        repeat (3) @(posedge refclk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
